// File: rtl/multi_edge_debounce.sv
// N-channel synchronise + consecutive-sample debounce with registered rise/fall pulses and level.
// Define MULTI_EDGE_DEBOUNCE_REPEAT_EN to build per-channel auto-repeat on rise.
module multi_edge_debounce_lane #(
    parameter int DEBOUNCE     = 1024,
    parameter int REPEAT_DELAY = 8192,
    parameter int REPEAT_RATE  = 2048
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(DEBOUNCE) + 1;

    logic          s1_q, s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          frise;

    // Any sample matching the accepted level restarts the filter count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        frise   = 1'b0;
        fall_d  = 1'b0;
        if (s_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                level_d = s_q;
                frise   = s_q;
                fall_d  = ~s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef MULTI_EDGE_DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rptd_q, rptd_d;
    logic          rep_fire;

    // rcnt counts cycles since the last rise pulse; rptd_q selects delay vs rate.
    always_comb begin
        rep_fire = 1'b0;
        if (level_q && !fall_d)
            rep_fire = rptd_q ? (rcnt_q == RW'(REPEAT_RATE - 1))
                              : (rcnt_q == RW'(REPEAT_DELAY - 1));
        rise_d = frise | rep_fire;
        rcnt_d = (!level_d || rise_d) ? '0 : rcnt_q + 1'b1;
        rptd_d = level_d & (rptd_q | rep_fire);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rcnt_q <= '0;
            rptd_q <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rptd_q <= rptd_d;
        end
    end
`else
    assign rise_d = frise;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s_q     <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s_q     <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

module multi_edge_debounce #(
    parameter int N            = 4,
    parameter int DEBOUNCE     = 1024,
    parameter int REPEAT_DELAY = 8192,
    parameter int REPEAT_RATE  = 2048
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         any_edge
);
    multi_edge_debounce_lane #(
        .DEBOUNCE    (DEBOUNCE),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_lane [N-1:0] (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (in),
        .level_o(level),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign any_edge = |{rise, fall};
endmodule
